fnd_scan_cntr: RTL and testbench
================================

# fnd_scan_cntr

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It accepts a 16-bit value of four 4-bit nibbles, usually the BCD output of the binary-to-BCD converter, through a valid/ready handshake. It scans the digits at a programmable rate and drives active-low segment and digit-enable lines. The display value changes only at frame boundaries, so no digit ever shows a mix of old and new data.

## Interface
- SCAN_DIV, 100000: clock cycles each digit stays enabled (1 ms at 100 MHz); legal range 2..2^20.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- value  in  16  four nibbles; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
- dp  in  4  decimal-point request per digit, active-high; sampled live, not latched.
- value_valid  in  1  offer of `value`.
- value_ready  out  1  high when a new value can be accepted.
- seg_7  out  8  segments {a,b,c,d,e,f,g,dp}, active-low.
- com  out  4  digit enables, active-low, one-hot-zero; com[0] is digit 0.

## Operation
- **Prescaler.** div_cnt counts 0..SCAN_DIV-1 and wraps. `tick` is asserted in the cycle div_cnt == SCAN_DIV-1.
- **Digit index.** idx (2 bits) increments on tick and wraps 3→0. A frame boundary is a tick while idx == 3.
- **Registers.** Two 16-bit registers: `pend_reg` and `disp_reg`, plus a `pend_full` flag.
- **value_ready** = ~pend_full.
- **Accept.** When value_valid && value_ready: pend_reg <= value, pend_full <= 1.
  - value_valid while value_ready is low is ignored; the value is dropped and the upstream must retry.
- **Frame boundary.** If pend_full was already 1 before the cycle: disp_reg <= pend_reg, pend_full <= 0.
  - An accept in the same cycle as a frame boundary is not transferred at that boundary; it waits for the next one.
- **Segment encode.** Nibble n = disp_reg[4*idx+3 : 4*idx]. Segment bits [7:1] use the codebase hex table (bit 0 set to 1 here; the dp bit is overwritten below):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
  - seg_7[0] = ~dp[idx].
- **Digit enable.** com = ~(4'b0001 << idx).
- **Reset values.** div_cnt=0, idx=0, disp_reg=0, pend_reg=0, pend_full=0, seg_7=8'hFF, com=4'hF, value_ready=1.

## Timing
- seg_7 and com are registered. They reflect idx, disp_reg and dp with 1-cycle latency.
- First cycle after reset release: outputs still at their reset values. From the second cycle: com=4'b1110, seg_7=8'b0000_0011 ("0").
- Each digit is shown for exactly SCAN_DIV cycles; one frame is 4*SCAN_DIV cycles. Order: digit 0, 1, 2, 3, 0, ...
- Accept to display:
  - value_ready falls 1 cycle after accept.
  - disp_reg updates at the first frame boundary strictly after the accept cycle.
  - value_ready rises 1 cycle after that boundary.
  - Worst-case latency from accept to the new digit 0 on the outputs: 4*SCAN_DIV + 2 cycles.
- Reset asserted mid-frame or mid-handshake: all state returns to its reset value on the next edge, and any pending value is discarded.
- Changes on dp reach seg_7 1 cycle later on the currently enabled digit.

## Configuration
- **LEADING_ZERO_BLANK_EN defined:**
  - Digit k (k = 3, 2, 1) is blanked when its nibble and every higher nibble of disp_reg are 0. Digit 0 is never blanked.
  - On a blanked digit, seg_7[7:1] = 7'h7F while seg_7[0] still follows dp. com scanning is unchanged.
- **LEADING_ZERO_BLANK_EN undefined:** all four digits always display their nibble. No blanking logic is synthesized.

## Test plan
- **Reset and scan (SCAN_DIV=4, macro off).**
  - Stimulus: release reset.
  - Required: com sequences 1110, 1101, 1011, 0111, 4 cycles each, starting at cycle 2. seg_7 = 8'h03 on every digit.
- **Load at frame boundary.**
  - Stimulus: accept 16'h1234 in cycle 5, mid-frame.
  - Required: value_ready low from cycle 6. disp_reg unchanged until the next idx 3→0 tick, after which the digits read 4,3,2,1 (seg 8'h99, 8'h0D, 8'h25, 8'h9F). value_ready high 1 cycle after that tick.
- **Back-pressure.**
  - Stimulus: offer 16'hAAAA while pending, then 16'h5678 after value_ready rises.
  - Required: AAAA never displayed; 5678 displayed after the following boundary.
- **Simultaneous accept and boundary.**
  - Stimulus: accept 16'h00FF in the boundary cycle.
  - Required: the display holds its old value for one more frame, then shows 00FF.
- **Blanking (macro on).**
  - Stimulus: load 16'h0042, dp=4'b0100.
  - Required: digits 3 and 2 have seg_7[7:1]=7'h7F; digit 2 has seg_7=8'hFE; digits 1 and 0 show 4 and 2. Load 16'h0000: only digit 0 shows "0".
- **Reset mid-operation.**
  - Stimulus: assert reset_n=0 for 1 cycle while pend_full=1 and idx=2.
  - Required: next cycle seg_7=8'hFF, com=4'hF, value_ready=1. The scan restarts at digit 0 showing "0".

Source files
------------

// File: rtl/fnd_scan_cntr.sv
// fnd_scan_cntr: 4-digit common-anode 7-segment scan driver, display value swapped only at frame boundaries.
// Optional define LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module fnd_scan_cntr #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [7:0]  seg_7,
    output logic [3:0]  com
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] r_div;
    logic [1:0]    r_idx;
    logic [15:0]   r_pend;
    logic [15:0]   r_disp;
    logic          r_pend_full;
    logic [7:0]    r_seg;
    logic [3:0]    r_com;
    logic          w_tick;
    logic          w_frame;
    logic          w_accept;
    logic          w_blank;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;

    assign w_tick      = r_div == CW'(SCAN_DIV - 1);
    assign w_frame     = w_tick && r_idx == 2'd3;
    assign w_accept    = value_valid && !r_pend_full;
    assign w_nib       = r_disp[{r_idx, 2'b00} +: 4];
    assign value_ready = !r_pend_full;
    assign seg_7       = r_seg;
    assign com         = r_com;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] w_lz;
    assign w_lz[3] = r_disp[15:12] == 4'h0;
    assign w_lz[2] = w_lz[3] && r_disp[11:8] == 4'h0;
    assign w_lz[1] = w_lz[2] && r_disp[7:4] == 4'h0;
    assign w_lz[0] = 1'b0;
    assign w_blank = w_lz[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    // Hex nibble to active-low {a,b,c,d,e,f,g} pattern
    always_comb begin
        case (w_nib)
            4'h0:    w_hex = 7'b0000001;
            4'h1:    w_hex = 7'b1001111;
            4'h2:    w_hex = 7'b0010010;
            4'h3:    w_hex = 7'b0000110;
            4'h4:    w_hex = 7'b1001100;
            4'h5:    w_hex = 7'b0100100;
            4'h6:    w_hex = 7'b0100000;
            4'h7:    w_hex = 7'b0001111;
            4'h8:    w_hex = 7'b0000000;
            4'h9:    w_hex = 7'b0001100;
            4'hA:    w_hex = 7'b0001000;
            4'hB:    w_hex = 7'b1100000;
            4'hC:    w_hex = 7'b0110001;
            4'hD:    w_hex = 7'b1000010;
            4'hE:    w_hex = 7'b0110000;
            default: w_hex = 7'b0111000;
        endcase
    end

    // Prescaler and digit index; index advances once per SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            r_idx <= w_tick ? r_idx + 2'd1 : r_idx;
        end
    end

    // Pending slot: accept only when empty, hand over to display at a frame boundary
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend      <= 16'h0000;
            r_disp      <= 16'h0000;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend      <= value;
            r_pend_full <= 1'b1;
        end else if (w_frame && r_pend_full) begin
            r_disp      <= r_pend;
            r_pend_full <= 1'b0;
        end
    end

    // Registered segment and digit-enable outputs; dp is taken live
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seg <= 8'hFF;
            r_com <= 4'hF;
        end else begin
            r_seg <= {w_blank ? 7'h7F : w_hex, ~dp[r_idx]};
            r_com <= ~(4'b0001 << r_idx);
        end
    end
endmodule

// File: tb/tb_fnd_scan_cntr.sv
// tb_fnd_scan_cntr: table-driven directed bench for fnd_scan_cntr at SCAN_DIV=4.
module tb_fnd_scan_cntr;
    typedef struct {
        logic        vld;
        logic [15:0] val;
        logic [3:0]  d;
        int          n;
        logic [7:0]  seg;
        logic [3:0]  com;
        logic        rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        value_valid = 1'b0;
    logic        value_ready;
    logic [7:0]  seg_7;
    logic [3:0]  com;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl[$];

    fnd_scan_cntr #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .value(value),
        .dp(dp),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .seg_7(seg_7),
        .com(com)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic vld, logic [15:0] val, logic [3:0] d, int n,
                                logic [7:0] seg, logic [3:0] c, logic rdy);
        vec_t v;
        v.vld = vld; v.val = val; v.d = d; v.n = n; v.seg = seg; v.com = c; v.rdy = rdy;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        bit found;
`ifdef LEADING_ZERO_BLANK_EN
        tbl.push_back(mk(1, 16'h0042, 4'b0100, 1, 8'h03, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 3, 8'h03, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'hFF, 4'hD, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'hFE, 4'hB, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 3, 8'hFF, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 1, 8'hFF, 4'h7, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'h25, 4'hE, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'h99, 4'hD, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'hFE, 4'hB, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'hFF, 4'h7, 1));
        tbl.push_back(mk(1, 16'h0000, 4'b0100, 1, 8'h25, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 3, 8'h25, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'h99, 4'hD, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 4, 8'hFE, 4'hB, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 3, 8'hFF, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'b0100, 1, 8'hFF, 4'h7, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0000, 4, 8'h03, 4'hE, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0000, 4, 8'hFF, 4'hD, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0000, 4, 8'hFF, 4'hB, 1));
        tbl.push_back(mk(0, 16'h0000, 4'b0000, 4, 8'hFF, 4'h7, 1));
`else
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h03, 4'hE, 1));
        tbl.push_back(mk(1, 16'h1234, 4'h0, 1, 8'h03, 4'hD, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 3, 8'h03, 4'hD, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h03, 4'hB, 0));
        tbl.push_back(mk(1, 16'hAAAA, 4'h0, 1, 8'h03, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 2, 8'h03, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 1, 8'h03, 4'h7, 1));
        tbl.push_back(mk(1, 16'h5678, 4'h0, 1, 8'h99, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 3, 8'h99, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h0D, 4'hD, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h25, 4'hB, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 3, 8'h9F, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 1, 8'h9F, 4'h7, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h1, 1, 8'h00, 4'hE, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 3, 8'h01, 4'hE, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h1F, 4'hD, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h41, 4'hB, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 3, 8'h49, 4'h7, 1));
        tbl.push_back(mk(1, 16'h00FF, 4'h0, 1, 8'h49, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h01, 4'hE, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h1F, 4'hD, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h41, 4'hB, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 3, 8'h49, 4'h7, 0));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 1, 8'h49, 4'h7, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h71, 4'hE, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h71, 4'hD, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h03, 4'hB, 1));
        tbl.push_back(mk(0, 16'h0000, 4'h0, 4, 8'h03, 4'h7, 1));
`endif
        step();
        step();
        chk("reset seg", seg_7, 8'hFF);
        chk("reset com", com, 4'hF);
        chk("reset ready", value_ready, 1'b1);
        reset_n = 1'b1;
        #1;
        chk("release seg", seg_7, 8'hFF);
        chk("release com", com, 4'hF);
        foreach (tbl[i]) begin
            value_valid = tbl[i].vld;
            value = tbl[i].val;
            dp = tbl[i].d;
            for (int c = 0; c < tbl[i].n; c++) begin
                step();
                value_valid = 1'b0;
                chk($sformatf("v%0d.%0d seg", i, c), seg_7, tbl[i].seg);
                chk($sformatf("v%0d.%0d com", i, c), com, tbl[i].com);
                chk($sformatf("v%0d.%0d ready", i, c), value_ready, tbl[i].rdy);
            end
        end
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (com == 4'hE) begin found = 1; break; end
        end
        chk("wait digit0", found, 1'b1);
        value = 16'h9999;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        chk("rst accept ready", value_ready, 1'b0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (com == 4'hB) begin found = 1; break; end
        end
        chk("wait digit2", found, 1'b1);
        chk("pending at idx2", value_ready, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst seg", seg_7, 8'hFF);
        chk("midrst com", com, 4'hF);
        chk("midrst ready", value_ready, 1'b1);
        step();
        chk("restart seg", seg_7, 8'h03);
        chk("restart com", com, 4'hE);
        repeat (3) step();
        chk("restart hold com", com, 4'hE);
        step();
        chk("restart digit1 com", com, 4'hD);
        repeat (12) step();
        chk("discard seg", seg_7, 8'h03);
        chk("discard com", com, 4'hE);
        chk("discard ready", value_ready, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
